// File: rtl/matmul_sequencer_if.sv
// Operand-memory, multiply-unit and result-memory bus of the matmul sequencer.
// master = sequencer side; slave = memories and multiply unit.
interface matmul_sequencer_if #(
  parameter int unsigned M  = 2,
  parameter int unsigned N  = 2,
  parameter int unsigned P  = 2,
  parameter int unsigned DW = 32
);
  localparam int unsigned AAW = (M * N > 1) ? $clog2(M * N) : 1;
  localparam int unsigned BAW = (N * P > 1) ? $clog2(N * P) : 1;
  localparam int unsigned CAW = (M * P > 1) ? $clog2(M * P) : 1;
  localparam int unsigned CW  = 2 * DW + $clog2(N);

  logic [AAW-1:0]  a_addr;
  logic [DW-1:0]   a_data;
  logic [BAW-1:0]  b_addr;
  logic [DW-1:0]   b_data;
  logic            mul_start;
  logic [DW-1:0]   mul_a;
  logic [DW-1:0]   mul_b;
  logic [2*DW-1:0] mul_product;
  logic            mul_done;
  logic            c_we;
  logic [CAW-1:0]  c_addr;
  logic [CW-1:0]   c_data;

  modport master (
    output a_addr, b_addr, mul_start, mul_a, mul_b, c_we, c_addr, c_data,
    input  a_data, b_data, mul_product, mul_done
  );

  modport slave (
    input  a_addr, b_addr, mul_start, mul_a, mul_b, c_we, c_addr, c_data,
    output a_data, b_data, mul_product, mul_done
  );
endinterface

// File: rtl/matmul_sequencer.sv
// Control FSM for C = A x B over a shared start/done multiply unit.
// Optional multiply timeout enabled by defining MMS_TIMEOUT_EN.
module matmul_sequencer #(
  parameter int unsigned M       = 2,
  parameter int unsigned N       = 2,
  parameter int unsigned P       = 2,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 128
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  output logic busy,
  output logic done,
  output logic error,
  matmul_sequencer_if.master bus
);
  localparam int unsigned AAW = (M * N > 1) ? $clog2(M * N) : 1;
  localparam int unsigned BAW = (N * P > 1) ? $clog2(N * P) : 1;
  localparam int unsigned CAW = (M * P > 1) ? $clog2(M * P) : 1;
  localparam int unsigned CW  = 2 * DW + $clog2(N);
  localparam int unsigned IW  = (M > 1) ? $clog2(M) : 1;
  localparam int unsigned JW  = (P > 1) ? $clog2(P) : 1;
  localparam int unsigned KW  = (N > 1) ? $clog2(N) : 1;

  if (M == 0 || N == 0 || P == 0 || DW == 0 || TIMEOUT == 0) begin : g_param_check
    $error("matmul_sequencer: all parameters must be non-zero");
  end

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    RDWAIT,
    MREQ,
    MWAIT,
    WRITE,
    DONE
  } state_t;

  state_t        state;
  logic [IW-1:0] i, ni;
  logic [JW-1:0] j, nj;
  logic [KW-1:0] k;
  logic [CW-1:0] acc;
  logic [CW-1:0] acc_sum;
  logic          k_last;
  logic          ij_last;

`ifdef MMS_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt;
`else
  assign error = 1'b0;
`endif

  always_comb begin
    acc_sum = acc + CW'(bus.mul_product);
    k_last  = (k == KW'(N - 1));
    ij_last = (i == IW'(M - 1)) && (j == JW'(P - 1));
    nj      = (j == JW'(P - 1)) ? '0 : j + JW'(1);
    ni      = i;
    if (j == JW'(P - 1)) begin
      ni = (i == IW'(M - 1)) ? '0 : i + IW'(1);
    end
  end

  // Registered outputs are loaded on the transition into the state that owns
  // them: addresses are valid during FETCH, operands and mul_start during
  // MREQ, and c_we/c_addr/c_data during WRITE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      i               <= '0;
      j               <= '0;
      k               <= '0;
      acc             <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      bus.a_addr      <= '0;
      bus.b_addr      <= '0;
      bus.mul_start   <= 1'b0;
      bus.mul_a       <= '0;
      bus.mul_b       <= '0;
      bus.c_we        <= 1'b0;
      bus.c_addr      <= '0;
      bus.c_data      <= '0;
`ifdef MMS_TIMEOUT_EN
      error           <= 1'b0;
      tcnt            <= '0;
`endif
    end else begin
      bus.mul_start <= 1'b0;
      bus.c_we      <= 1'b0;
      done          <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= FETCH;
            busy       <= 1'b1;
            i          <= '0;
            j          <= '0;
            k          <= '0;
            acc        <= '0;
            bus.a_addr <= '0;
            bus.b_addr <= '0;
`ifdef MMS_TIMEOUT_EN
            error      <= 1'b0;
`endif
          end
        end
        FETCH: state <= RDWAIT;
        RDWAIT: begin
          bus.mul_a     <= bus.a_data;
          bus.mul_b     <= bus.b_data;
          bus.mul_start <= 1'b1;
          state         <= MREQ;
        end
        MREQ: begin
          state <= MWAIT;
`ifdef MMS_TIMEOUT_EN
          tcnt  <= '0;
`endif
        end
        MWAIT: begin
          if (bus.mul_done) begin
            acc <= acc_sum;
            if (k_last) begin
              bus.c_we   <= 1'b1;
              bus.c_addr <= CAW'(32'(i) * P + 32'(j));
              bus.c_data <= acc_sum;
              state      <= WRITE;
            end else begin
              k          <= k + KW'(1);
              bus.a_addr <= AAW'(32'(i) * N + 32'(k) + 1);
              bus.b_addr <= BAW'((32'(k) + 1) * P + 32'(j));
              state      <= FETCH;
            end
          end
`ifdef MMS_TIMEOUT_EN
          else if (tcnt == TW'(TIMEOUT - 1)) begin
            error <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
`endif
        end
        WRITE: begin
          acc <= '0;
          k   <= '0;
          i   <= ni;
          j   <= nj;
          if (ij_last) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end else begin
            bus.a_addr <= AAW'(32'(ni) * N);
            bus.b_addr <= BAW'(32'(nj));
            state      <= FETCH;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_matmul_sequencer.sv
// Scoreboard bench for matmul_sequencer: a 2x2x2 instance with a slow
// multiply model and a 2x1x2 instance with a 1-cycle multiply model.
module tb_matmul_sequencer;
  localparam int unsigned DW = 32;
`ifdef MMS_TIMEOUT_EN
  localparam int unsigned MUL_LAT = 12;
`else
  localparam int unsigned MUL_LAT = 34;
`endif

  typedef struct {
    int unsigned  addr;
    logic [127:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start0 = 1'b0, busy0, done0, error0;
  logic start1 = 1'b0, busy1, done1, error1;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned wr0 = 0, dn0 = 0, wr1 = 0, dn1 = 0, cyc = 0, last1 = 0;
  bit          have_last1 = 1'b0;
  bit          hang0 = 1'b0;
  exp_t        q0[$], q1[$];
  exp_t        e0, e1;

  logic [DW-1:0] a0[4], b0[4], a1[2], b1[2];
  int unsigned   cnt0 = 0;
  bit            pend0 = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  matmul_sequencer_if #(.M(2), .N(2), .P(2), .DW(DW)) bus0 ();
  matmul_sequencer_if #(.M(2), .N(1), .P(2), .DW(DW)) bus1 ();

  matmul_sequencer #(.M(2), .N(2), .P(2), .DW(DW), .TIMEOUT(16)) dut0 (
    .clk(clk), .reset_n(reset_n), .start(start0), .busy(busy0),
    .done(done0), .error(error0), .bus(bus0.master)
  );

  matmul_sequencer #(.M(2), .N(1), .P(2), .DW(DW), .TIMEOUT(16)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start1), .busy(busy1),
    .done(done1), .error(error1), .bus(bus1.master)
  );

  // Operand memories with one cycle of read latency.
  always @(posedge clk) begin
    bus0.a_data <= a0[bus0.a_addr];
    bus0.b_data <= b0[bus0.b_addr];
    bus1.a_data <= a1[bus1.a_addr];
    bus1.b_data <= b1[bus1.b_addr];
  end

  // Multiply unit for dut0: mul_done MUL_LAT cycles after mul_start.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus0.mul_done    <= 1'b0;
      bus0.mul_product <= '0;
      pend0            <= 1'b0;
      cnt0             <= 0;
    end else begin
      bus0.mul_done <= 1'b0;
      if (bus0.mul_start) begin
        bus0.mul_product <= 64'(bus0.mul_a) * 64'(bus0.mul_b);
        cnt0             <= MUL_LAT - 1;
        pend0            <= 1'b1;
      end else if (pend0) begin
        if (cnt0 == 1) begin
          bus0.mul_done <= !hang0;
          pend0         <= 1'b0;
        end
        cnt0 <= cnt0 - 1;
      end
    end
  end

  // Multiply unit for dut1: single-cycle latency.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus1.mul_done    <= 1'b0;
      bus1.mul_product <= '0;
    end else begin
      bus1.mul_done    <= bus1.mul_start;
      bus1.mul_product <= 64'(bus1.mul_a) * 64'(bus1.mul_b);
    end
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Result monitors: every C write is popped against the scoreboard.
  always @(negedge clk) begin
    if (bus0.c_we) begin
      wr0++;
      if (q0.size() == 0) check("c0_unexpected_write", 1, 0);
      else begin
        e0 = q0.pop_front();
        check("c0_addr", 128'(bus0.c_addr), 128'(e0.addr));
        check("c0_data", 128'(bus0.c_data), e0.data);
      end
    end
    if (done0) dn0++;
    if (bus1.c_we) begin
      wr1++;
      if (have_last1) check("c1_element_cycles", cyc - last1, 5);
      last1      = cyc;
      have_last1 = 1'b1;
      if (q1.size() == 0) check("c1_unexpected_write", 1, 0);
      else begin
        e1 = q1.pop_front();
        check("c1_addr", 128'(bus1.c_addr), 128'(e1.addr));
        check("c1_data", 128'(bus1.c_data), e1.data);
      end
    end
    if (done1) dn1++;
  end

  task automatic load_small();
    a0 = '{32'd1, 32'd2, 32'd3, 32'd4};
    b0 = '{32'd5, 32'd6, 32'd7, 32'd8};
  endtask

  task automatic push_small();
    q0.push_back('{0, 128'd19});
    q0.push_back('{1, 128'd22});
    q0.push_back('{2, 128'd43});
    q0.push_back('{3, 128'd50});
  endtask

  task automatic pulse0();
    @(negedge clk) start0 = 1'b1;
    @(negedge clk) start0 = 1'b0;
  endtask

  task automatic wait_done0(input string tag);
    int unsigned n = 0, gaps = 0;
    while (!done0 && n < 3000) begin
      if (!busy0) gaps++;
      @(negedge clk);
      n++;
    end
    check({tag, "_done_seen"}, 128'(done0), 1);
    check({tag, "_busy_held"}, 128'(gaps), 0);
  endtask

  task automatic wait_wr0(input int unsigned target);
    int unsigned n = 0;
    while (wr0 < target && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("wr0_reached", 128'(wr0 >= target), 1);
  endtask

  task automatic wait_mulstart0();
    int unsigned n = 0;
    while (!bus0.mul_start && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("mul_start_seen", 128'(bus0.mul_start), 1);
  endtask

  task automatic finish0(input string tag, input int unsigned wb, input int unsigned db);
    repeat (4) @(negedge clk);
    check({tag, "_writes"}, 128'(wr0 - wb), 4);
    check({tag, "_done_pulses"}, 128'(dn0 - db), 1);
    check({tag, "_error"}, 128'(error0), 0);
    check({tag, "_scoreboard_empty"}, 128'(q0.size()), 0);
  endtask

  initial begin
    int unsigned wb, db, n;
    load_small();
    a1 = '{32'd3, 32'd4};
    b1 = '{32'd5, 32'd6};
    repeat (3) @(negedge clk);
    check("rst_busy", 128'(busy0), 0);
    check("rst_done", 128'(done0), 0);
    check("rst_error", 128'(error0), 0);
    check("rst_c_we", 128'(bus0.c_we), 0);
    check("rst_mul_start", 128'(bus0.mul_start), 0);
    check("rst_addrs", 128'({bus0.a_addr, bus0.b_addr, bus0.c_addr}), 0);
    check("rst_data", 128'({bus0.c_data, bus0.mul_a, bus0.mul_b}), 0);
    check("rst_busy1", 128'(busy1), 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Basic 2x2 product
    wb = wr0; db = dn0;
    push_small();
    pulse0();
    wait_done0("s1");
    finish0("s1", wb, db);

    // Full-width operands, no truncation
    a0 = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
    b0 = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    wb = wr0; db = dn0;
    q0.push_back('{0, 128'h1_FFFF_FFFC_0000_0002});
    q0.push_back('{1, 128'h1_FFFF_FFFC_0000_0002});
    q0.push_back('{2, 128'd0});
    q0.push_back('{3, 128'd0});
    pulse0();
    wait_done0("s2");
    finish0("s2", wb, db);

    // Start while busy is ignored
    load_small();
    wb = wr0; db = dn0;
    push_small();
    pulse0();
    wait_wr0(wb + 1);
    wait_mulstart0();
    repeat (3) @(negedge clk);
    pulse0();
    wait_done0("s3");
    finish0("s3", wb, db);

    // Reset during element 2 aborts; rerun is complete
    wb = wr0; db = dn0;
    push_small();
    pulse0();
    wait_wr0(wb + 2);
    wait_mulstart0();
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    q0.delete();
    repeat (3) @(negedge clk);
    check("s4_busy_in_reset", 128'(busy0), 0);
    check("s4_c_we_in_reset", 128'(bus0.c_we), 0);
    reset_n = 1'b1;
    repeat (60) @(negedge clk);
    check("s4_no_write_after_reset", 128'(wr0 - wb), 2);
    check("s4_no_done", 128'(dn0 - db), 0);
    check("s4_idle_after_reset", 128'(busy0), 0);
    wb = wr0; db = dn0;
    push_small();
    pulse0();
    wait_done0("s4");
    finish0("s4", wb, db);

`ifdef MMS_TIMEOUT_EN
    // Multiply never completes
    hang0 = 1'b1;
    wb = wr0; db = dn0;
    pulse0();
    wait_done0("s5");
    check("s5_error_set", 128'(error0), 1);
    repeat (4) @(negedge clk);
    check("s5_no_writes", 128'(wr0 - wb), 0);
    check("s5_done_pulses", 128'(dn0 - db), 1);
    check("s5_error_sticky", 128'(error0), 1);
    hang0 = 1'b0;
    wb = wr0; db = dn0;
    push_small();
    pulse0();
    check("s5_error_cleared", 128'(error0), 0);
    wait_done0("s5r");
    finish0("s5r", wb, db);
`endif

    // N=1 with a single-cycle multiplier
    q1.push_back('{0, 128'd15});
    q1.push_back('{1, 128'd18});
    q1.push_back('{2, 128'd20});
    q1.push_back('{3, 128'd24});
    @(negedge clk) start1 = 1'b1;
    @(negedge clk) start1 = 1'b0;
    n = 0;
    while (!done1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("s6_done_seen", 128'(done1), 1);
    repeat (4) @(negedge clk);
    check("s6_writes", 128'(wr1), 4);
    check("s6_done_pulses", 128'(dn1), 1);
    check("s6_error", 128'(error1), 0);
    check("s6_scoreboard_empty", 128'(q1.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
